// File: rtl/sample_mixer_pkg.sv
// Shared definitions for the sample mixer: frame-sync state encoding and
// the volume scale at which the mixer applies unity gain.
package sample_mixer_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } MixerState_t;

  localparam int unsigned UNITY_VOLUME = 256;

  localparam int SAMPLE_W = 16;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; the head entry is read straight from the storage
// array at the read pointer and forced to zero while the FIFO is empty.
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // The caller only pushes when space exists or a pop happens on the same edge.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; nothing reads it while empty, and
  // leaving it unreset lets it map onto plain register-file cells.
  always_ff @(posedge i_Clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign full      = (count == (PTR_W + 1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sample_mixer.sv
// Sums per-voice subsamples into frames, applies master volume and headroom
// shift with 16-bit saturation, and queues finished samples for the serializer.
module sample_mixer
  import sample_mixer_pkg::*;
#(
  parameter int VOICES     = 16,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic signed [SAMPLE_W-1:0] i_Subsample,
  input  logic                       i_SubsampleReady,
  input  logic                       i_SampleReady,
  input  logic [8:0]                 i_Volume,
  input  logic                       i_ClearFlags,
  output logic signed [SAMPLE_W-1:0] o_Sample,
  output logic                       o_Valid,
  input  logic                       i_Ready,
  output logic                       o_Clip,
  output logic                       o_Overrun,
  output logic                       o_FrameError
);

  localparam int ACC_W       = SAMPLE_W + $clog2(VOICES) + 1;
  localparam int CNT_W       = $clog2(VOICES + 2);
  localparam int VOL_SHIFT   = $clog2(UNITY_VOLUME);
  localparam int PROD_W      = ACC_W + 10;
  localparam int SCALE_SHIFT = VOL_SHIFT + SHIFT;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(VOICES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(VOICES + 1);

  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(32'sd32767);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-32'sd32768);

  MixerState_t state_q, state_d;

  logic signed [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]           cnt_q;
  logic signed [ACC_W-1:0]    sub_ext;
  logic signed [ACC_W-1:0]    frame_sum;
  logic [CNT_W-1:0]           frame_cnt;
  logic                       finalize;
  logic                       frame_err_set;

  logic                       fin_valid;
  logic signed [ACC_W-1:0]    fin_sum;
  logic [8:0]                 fin_vol;

  logic                       p1_valid;
  logic signed [PROD_W-1:0]   p1_prod;
  logic signed [PROD_W-1:0]   scaled;
  logic signed [SAMPLE_W-1:0] sat_sample;
  logic                       sat_clip;
  logic                       clip_set;

  logic                       p2_valid;
  logic signed [SAMPLE_W-1:0] p2_sample;

  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_pop;
  logic                       fifo_push;
  logic                       overrun_set;
  logic [SAMPLE_W-1:0]        fifo_head;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state_q <= SYNC;
    else         state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (state_q == SYNC && i_SampleReady) state_d = RUN;
  end

  always_comb begin
    sub_ext   = i_SubsampleReady ? {{(ACC_W - SAMPLE_W){i_Subsample[SAMPLE_W-1]}}, i_Subsample}
                                 : '0;
    frame_sum = acc_q + sub_ext;
    frame_cnt = cnt_q;
    if (i_SubsampleReady && cnt_q != CNT_MAX) frame_cnt = cnt_q + CNT_W'(1);
  end

  assign finalize      = (state_q == RUN) && i_SampleReady;
  assign frame_err_set = finalize && (frame_cnt != CNT_FULL);

  // Subsamples seen while still hunting for a frame boundary are ignored.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      fin_valid <= 1'b0;
      fin_sum   <= '0;
      fin_vol   <= '0;
    end else begin
      fin_valid <= 1'b0;
      if (state_q == RUN) begin
        if (i_SampleReady) begin
          acc_q <= '0;
          cnt_q <= '0;
          if (frame_cnt == CNT_FULL) begin
            fin_valid <= 1'b1;
            fin_sum   <= frame_sum;
            fin_vol   <= i_Volume;
          end
        end else begin
          acc_q <= frame_sum;
          cnt_q <= frame_cnt;
        end
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      p1_valid <= 1'b0;
      p1_prod  <= '0;
    end else begin
      p1_valid <= fin_valid;
      p1_prod  <= PROD_W'(fin_sum) * PROD_W'($signed({1'b0, fin_vol}));
    end
  end

  always_comb begin
    scaled     = p1_prod >>> SCALE_SHIFT;
    sat_sample = scaled[SAMPLE_W-1:0];
    sat_clip   = 1'b0;
    if (scaled > SAT_MAX) begin
      sat_sample = SAT_MAX[SAMPLE_W-1:0];
      sat_clip   = 1'b1;
    end else if (scaled < SAT_MIN) begin
      sat_sample = SAT_MIN[SAMPLE_W-1:0];
      sat_clip   = 1'b1;
    end
  end

  assign clip_set = p1_valid && sat_clip;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      p2_valid  <= 1'b0;
      p2_sample <= '0;
    end else begin
      p2_valid  <= p1_valid;
      p2_sample <= sat_sample;
    end
  end

  // A full FIFO still takes the push when the consumer drains an entry on the same edge.
  assign fifo_pop    = !fifo_empty && i_Ready;
  assign fifo_push   = p2_valid && (!fifo_full || fifo_pop);
  assign overrun_set = p2_valid && !fifo_push;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .push      (fifo_push),
    .push_data (p2_sample),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (fifo_head)
  );

  assign o_Valid  = !fifo_empty;
  assign o_Sample = $signed(fifo_head);

  // A set event on the same edge as a clear keeps the flag raised.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Clip       <= 1'b0;
      o_Overrun    <= 1'b0;
      o_FrameError <= 1'b0;
    end else begin
      o_Clip       <= clip_set      || (o_Clip       && !i_ClearFlags);
      o_Overrun    <= overrun_set   || (o_Overrun    && !i_ClearFlags);
      o_FrameError <= frame_err_set || (o_FrameError && !i_ClearFlags);
    end
  end

endmodule

// File: tb/tb_sample_mixer.sv
// Directed and randomized checks of sample_mixer against a frame-level
// arithmetic model of mixing, volume, headroom shift and saturation.
module tb_sample_mixer;

  localparam int VOICES     = 16;
  localparam int SHIFT      = 2;
  localparam int FIFO_DEPTH = 4;

  typedef int iq_t[$];

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] subsample = '0;
  logic               sub_rdy = 1'b0;
  logic               smp_rdy = 1'b0;
  logic [8:0]         volume = 9'd256;
  logic               clear_flags = 1'b0;
  logic               ready = 1'b0;
  logic signed [15:0] o_sample;
  logic               o_valid;
  logic               o_clip;
  logic               o_overrun;
  logic               o_frame_error;

  int n_assert = 0;
  int n_fail   = 0;

  sample_mixer #(
    .VOICES     (VOICES),
    .SHIFT      (SHIFT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_Clock          (clock),
    .i_Reset          (reset),
    .i_Subsample      (subsample),
    .i_SubsampleReady (sub_rdy),
    .i_SampleReady    (smp_rdy),
    .i_Volume         (volume),
    .i_ClearFlags     (clear_flags),
    .o_Sample         (o_sample),
    .o_Valid          (o_valid),
    .i_Ready          (ready),
    .o_Clip           (o_clip),
    .o_Overrun        (o_overrun),
    .o_FrameError     (o_frame_error)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic iq_t rep(input int v, input int n);
    iq_t q;
    for (int i = 0; i < n; i++) q.push_back(v);
    return q;
  endfunction

  // Mixed sample = floor(sum * volume / 2^(8+SHIFT)), clamped to 16 bits.
  function automatic int model(input iq_t vals, input int vol, output bit clip);
    longint s = 0;
    longint p;
    foreach (vals[i]) s += vals[i];
    p    = (s * vol) >>> (8 + SHIFT);
    clip = 1'b0;
    if (p > 32767) begin
      p    = 32767;
      clip = 1'b1;
    end else if (p < -32768) begin
      p    = -32768;
      clip = 1'b1;
    end
    return int'(p);
  endfunction

  // Drives one frame; returns 1ns after the edge that samples i_SampleReady.
  task automatic send_frame(input iq_t vals, input int vol, input bit standalone_last);
    volume = 9'(vol);
    for (int i = 0; i < vals.size(); i++) begin
      subsample = 16'(vals[i]);
      sub_rdy   = 1'b1;
      smp_rdy   = !standalone_last && (i == vals.size() - 1);
      tick();
    end
    if (standalone_last) begin
      sub_rdy = 1'b0;
      smp_rdy = 1'b1;
      tick();
    end
    sub_rdy = 1'b0;
    smp_rdy = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int exp);
    int waited = 0;
    while (!o_valid && waited < 10) begin
      tick();
      waited++;
    end
    check({tag, " valid"}, o_valid, 1);
    check({tag, " sample"}, o_sample, exp);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({tag, " drained"}, o_valid, 0);
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    iq_t vals;
    int  exp_v;
    bit  exp_clip;
    int  vol;

    // Reset state
    idle(2);
    reset = 1'b0;
    check("reset valid", o_valid, 0);
    check("reset sample", o_sample, 0);
    check("reset clip", o_clip, 0);
    check("reset overrun", o_overrun, 0);
    check("reset frame_error", o_frame_error, 0);

    // Sync frame is discarded without error
    vals.delete();
    for (int i = 0; i < 11; i++) vals.push_back(int'($urandom_range(0, 65535)) - 32768);
    send_frame(vals, 256, 1'b0);
    idle(6);
    check("sync no output", o_valid, 0);
    check("sync no frame_error", o_frame_error, 0);

    // Nominal frame with exact latency
    send_frame(rep(1000, 16), 256, 1'b0);
    idle(2);
    check("nominal valid before E+3", o_valid, 0);
    tick();
    check("nominal valid after E+3", o_valid, 1);
    exp_v = model(rep(1000, 16), 256, exp_clip);
    expect_out("nominal", exp_v);
    check("nominal clip", o_clip, 0);
    check("nominal overrun", o_overrun, 0);
    check("nominal frame_error", o_frame_error, 0);

    // Half volume, negative subsamples; then zero volume
    send_frame(rep(-1000, 16), 128, 1'b0);
    expect_out("half volume", model(rep(-1000, 16), 128, exp_clip));
    send_frame(rep(1000, 16), 0, 1'b0);
    expect_out("zero volume", model(rep(1000, 16), 0, exp_clip));

    // Clipping both rails
    send_frame(rep(32767, 16), 256, 1'b0);
    expect_out("clip high", 32767);
    check("clip high flag", o_clip, 1);
    pulse_clear();
    check("clip cleared", o_clip, 0);
    send_frame(rep(-32768, 16), 256, 1'b0);
    expect_out("clip low", -32768);
    check("clip low flag", o_clip, 1);
    pulse_clear();
    check("clip cleared again", o_clip, 0);

    // Short frame ends with a standalone i_SampleReady
    send_frame(rep(1000, 15), 256, 1'b1);
    check("frame_error set", o_frame_error, 1);
    idle(6);
    check("short frame dropped", o_valid, 0);
    send_frame(rep(1000, 16), 256, 1'b0);
    expect_out("after frame error", 4000);
    pulse_clear();
    check("frame_error cleared", o_frame_error, 0);

    // Randomized frames and volumes
    for (int f = 0; f < 6; f++) begin
      vals.delete();
      for (int i = 0; i < VOICES; i++) vals.push_back(int'($urandom_range(0, 65535)) - 32768);
      vol   = int'($urandom_range(0, 511));
      exp_v = model(vals, vol, exp_clip);
      send_frame(vals, vol, ($urandom_range(0, 1) == 1) ? 1'b0 : 1'b0);
      expect_out($sformatf("random %0d", f), exp_v);
      check($sformatf("random %0d clip", f), o_clip, int'(exp_clip));
      pulse_clear();
    end

    // Overrun: five frames with the consumer stalled
    for (int f = 1; f <= 5; f++) send_frame(rep(100 * f, 16), 256, 1'b0);
    check("overrun before fifth push", o_overrun, 0);
    idle(3);
    check("overrun after fifth push", o_overrun, 1);
    ready = 1'b1;
    for (int k = 1; k <= FIFO_DEPTH; k++) begin
      check($sformatf("overrun drain %0d valid", k), o_valid, 1);
      check($sformatf("overrun drain %0d sample", k), o_sample, model(rep(100 * k, 16), 256, exp_clip));
      tick();
    end
    ready = 1'b0;
    check("overrun drained", o_valid, 0);
    pulse_clear();
    check("overrun cleared", o_overrun, 0);

    // Full FIFO with push and pop on the same edge
    for (int f = 1; f <= 5; f++) begin
      send_frame(rep(10 * f, 16), 256, 1'b0);
      if (f == 5) begin
        idle(2);
        ready = 1'b1;
        tick();
        ready = 1'b0;
      end
    end
    check("push+pop full no overrun", o_overrun, 0);
    ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("push+pop drain %0d", k), o_sample, 40 * k);
      tick();
    end
    ready = 1'b0;
    check("push+pop drained", o_valid, 0);

    // Reset mid-frame with two samples queued and a flag raised
    send_frame(rep(1000, 15), 256, 1'b1);
    send_frame(rep(1000, 16), 256, 1'b0);
    send_frame(rep(2000, 16), 256, 1'b0);
    idle(4);
    check("pre-reset valid", o_valid, 1);
    check("pre-reset frame_error", o_frame_error, 1);
    for (int i = 0; i < 7; i++) begin
      subsample = 16'sd1000;
      sub_rdy   = 1'b1;
      tick();
    end
    sub_rdy = 1'b0;
    reset   = 1'b1;
    tick();
    reset   = 1'b0;
    check("mid reset valid", o_valid, 0);
    check("mid reset sample", o_sample, 0);
    check("mid reset clip", o_clip, 0);
    check("mid reset overrun", o_overrun, 0);
    check("mid reset frame_error", o_frame_error, 0);
    send_frame(rep(1000, 16), 256, 1'b0);
    idle(6);
    check("post-reset sync frame dropped", o_valid, 0);
    check("post-reset sync no error", o_frame_error, 0);
    send_frame(rep(1000, 16), 256, 1'b0);
    expect_out("post-reset frame", 4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
